// File: rtl/yutorina_bus_slave_ram.sv
// Bus slave RAM: 2**ADDR_W x 32-bit words behind a cs_/as_/rdy_ handshake with a fixed
// number of wait states. Both the write commit and the read capture happen on the edge entering READY.
module yutorina_bus_slave_ram #(
   parameter int unsigned WAIT_CYCLES = 1,  // legal 0..7
   parameter int unsigned ADDR_W      = 8   // legal 1..29
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs_,
   input  logic        as_,
   input  logic        rw,
   input  logic [29:0] addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        rdy_
);

   localparam int unsigned Depth   = 2 ** ADDR_W;
   localparam logic [2:0]  CntInit = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rw_q, rw_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic              rdy_q, rdy_d;
   logic [31:0]       rd_data_q, rd_data_d;
   logic [31:0]       mem_q [Depth];

   logic              req, accept, commit, mem_we;
   logic [ADDR_W-1:0] acc_addr;
   logic              acc_rw;
   logic [31:0]       acc_data;

   // Upper address bits alias onto the same words.
   if (ADDR_W < 30) begin : g_unused_addr
      logic unused_addr;
      assign unused_addr = ^addr[29:ADDR_W];
   end

   assign req    = !cs_ && !as_;
   assign accept = (state_q == StIdle) && req;

   // With zero wait states the commit edge is also the accept edge, so use the live inputs.
   assign acc_addr = (state_q == StIdle) ? addr[ADDR_W-1:0] : addr_q;
   assign acc_rw   = (state_q == StIdle) ? rw : rw_q;
   assign acc_data = (state_q == StIdle) ? wr_data : wr_data_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = StReady;
               end else begin
                  state_d = StWait;
                  cnt_d   = CntInit;
               end
            end
         end
         StWait: begin
            if (!req) begin
               state_d = StIdle;
               cnt_d   = 3'd0;
            end else if (cnt_q == 3'd0) begin
               state_d = StReady;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         StReady: state_d = StIdle;
         default: begin
            state_d = StIdle;
            cnt_d   = 3'd0;
         end
      endcase
   end

   always_comb begin
      commit    = (state_d == StReady) && (state_q != StReady);
      mem_we    = commit && !acc_rw;
      rdy_d     = !commit;
      rd_data_d = (commit && acc_rw) ? mem_q[acc_addr] : 32'd0;
      addr_d    = accept ? addr[ADDR_W-1:0] : addr_q;
      rw_d      = accept ? rw : rw_q;
      wr_data_d = accept ? wr_data : wr_data_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdy_q     <= 1'b1;
         rd_data_q <= 32'd0;
         addr_q    <= '0;
         rw_q      <= 1'b0;
         wr_data_q <= 32'd0;
      end else begin
         rdy_q     <= rdy_d;
         rd_data_q <= rd_data_d;
         addr_q    <= addr_d;
         rw_q      <= rw_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Storage has no reset; rst only blocks a commit while it is held.
   always_ff @(posedge clk) begin
      if (rst && mem_we) begin
         mem_q[acc_addr] <= acc_data;
      end
   end

   assign rdy_    = rdy_q;
   assign rd_data = rd_data_q;

endmodule
